fetch_sequencer: RTL and testbench



---
 rtl/fetch_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: multi-cycle FETCH/DECODE/EXEC/WB control for the 8-bit core.
// Optional macro FETCH_SEQ_ILLEGAL_TRAP_EN traps reserved opcodes B-E into HALT.
module fetch_sequencer (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Start,
    input  logic [3:0]  DataOp,
    input  logic [2:0]  Datars,
    input  logic [2:0]  Datart,
    input  logic [2:0]  Datard,
    input  logic [7:0]  Datai,
    input  logic        Zero,
    output logic [7:0]  Addr,
    output logic [2:0]  RsAddr,
    output logic [2:0]  RtAddr,
    output logic [2:0]  RdAddr,
    output logic [7:0]  Imm,
    output logic [2:0]  AluOp,
    output logic        AluSrcImm,
    output logic        RegWe,
    output logic        Busy,
    output logic        Halted,
    output logic        Illegal,
    output logic [15:0] RetiredCnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_ADDI = 4'h6;
    localparam logic [3:0] OP_LI   = 4'h7;
    localparam logic [3:0] OP_BEQ  = 4'h8;
    localparam logic [3:0] OP_BNE  = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_HLT  = 4'hF;

    state_t      state, state_nx;
    logic [7:0]  pc, pc_nx;
    logic [3:0]  ir_op;
    logic [2:0]  ir_rs, ir_rt, ir_rd;
    logic [7:0]  ir_imm;
    logic [15:0] retired_cnt;
    logic        retire;
    logic        is_alu;
    logic        is_rsv;
    logic        taken;

    assign is_alu = (ir_op >= OP_ADD) && (ir_op <= OP_LI);
    assign is_rsv = (ir_op > OP_JMP) && (ir_op < OP_HLT);
    assign taken  = ((ir_op == OP_BEQ) && Zero) ||
                    ((ir_op == OP_BNE) && !Zero);

`ifdef FETCH_SEQ_ILLEGAL_TRAP_EN
    logic trap;
    logic illegal_q;
    assign trap    = is_rsv;
    assign Illegal = illegal_q;
`else
    logic trap;
    assign trap    = 1'b0;
    assign Illegal = 1'b0;
`endif

    // Next state, next PC and retire strobe
    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        retire   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (Start) state_nx = S_FETCH;
            end
            S_FETCH:  state_nx = S_DECODE;
            S_DECODE: state_nx = S_EXEC;
            S_EXEC: begin
                if (is_alu) begin
                    state_nx = S_WB;
                end else if (ir_op == OP_HLT || trap) begin
                    state_nx = S_HALT;
                end else begin
                    state_nx = S_FETCH;
                    retire   = 1'b1;
                    if (ir_op == OP_JMP || taken) pc_nx = ir_imm;
                    else pc_nx = pc + 8'd1;
                end
            end
            S_WB: begin
                state_nx = S_FETCH;
                retire   = 1'b1;
                pc_nx    = pc + 8'd1;
            end
            S_HALT: begin
                if (Start) begin
                    state_nx = S_FETCH;
                    pc_nx    = 8'h00;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // State, PC, instruction register and retired counter
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state       <= S_IDLE;
            pc          <= 8'h00;
            ir_op       <= 4'h0;
            ir_rs       <= 3'h0;
            ir_rt       <= 3'h0;
            ir_rd       <= 3'h0;
            ir_imm      <= 8'h00;
            retired_cnt <= 16'h0000;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            if (state == S_FETCH) begin
                ir_op  <= DataOp;
                ir_rs  <= Datars;
                ir_rt  <= Datart;
                ir_rd  <= Datard;
                ir_imm <= Datai;
            end
            if (retire && retired_cnt != 16'hFFFF)
                retired_cnt <= retired_cnt + 16'd1;
        end
    end

`ifdef FETCH_SEQ_ILLEGAL_TRAP_EN
    // Sticky trap flag, cleared by reset or by restarting from HALT
    always_ff @(posedge Clk) begin
        if (!Rst_n)
            illegal_q <= 1'b0;
        else if (state == S_EXEC && trap)
            illegal_q <= 1'b1;
        else if (state == S_HALT && Start)
            illegal_q <= 1'b0;
    end
`endif

    // ALU control, held through WB so the write-back data stays stable
    always_comb begin
        AluOp     = 3'd0;
        AluSrcImm = 1'b0;
        if (state == S_EXEC || state == S_WB) begin
            unique case (1'b1)
                (ir_op == OP_SUB): AluOp = 3'd1;
                (ir_op == OP_AND): AluOp = 3'd2;
                (ir_op == OP_OR):  AluOp = 3'd3;
                (ir_op == OP_XOR): AluOp = 3'd4;
                (ir_op == OP_BEQ): AluOp = 3'd1;
                (ir_op == OP_BNE): AluOp = 3'd1;
                (ir_op == OP_ADDI): begin
                    AluOp     = 3'd0;
                    AluSrcImm = 1'b1;
                end
                (ir_op == OP_LI): begin
                    AluOp     = 3'd5;
                    AluSrcImm = 1'b1;
                end
                default: AluOp = 3'd0;
            endcase
        end
    end

    assign Addr       = pc;
    assign RsAddr     = ir_rs;
    assign RtAddr     = ir_rt;
    assign RdAddr     = ir_rd;
    assign Imm        = ir_imm;
    assign RegWe      = (state == S_WB) && Rst_n;
    assign Busy       = (state == S_FETCH) || (state == S_DECODE) ||
                        (state == S_EXEC)  || (state == S_WB);
    assign Halted     = (state == S_HALT);
    assign RetiredCnt = retired_cnt;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed programs with a write-back scoreboard.
// Honours FETCH_SEQ_ILLEGAL_TRAP_EN for the reserved-opcode case.
module tb_fetch_sequencer;

    logic        Clk = 1'b0;
    logic        Rst_n, Start, Zero;
    logic [3:0]  DataOp;
    logic [2:0]  Datars, Datart, Datard;
    logic [7:0]  Datai, Addr, Imm;
    logic [2:0]  RsAddr, RtAddr, RdAddr, AluOp;
    logic        AluSrcImm, RegWe, Busy, Halted, Illegal;
    logic [15:0] RetiredCnt;

    logic [20:0] mem [256];
    logic [20:0] cur;

    typedef struct packed {
        logic [2:0] rd;
        logic [2:0] op;
        logic       src;
    } wb_t;
    wb_t sbq[$];

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    assign cur    = mem[Addr];
    assign DataOp = cur[20:17];
    assign Datars = cur[16:14];
    assign Datart = cur[13:11];
    assign Datard = cur[10:8];
    assign Datai  = cur[7:0];

    fetch_sequencer dut (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start),
        .DataOp(DataOp), .Datars(Datars), .Datart(Datart),
        .Datard(Datard), .Datai(Datai), .Zero(Zero),
        .Addr(Addr), .RsAddr(RsAddr), .RtAddr(RtAddr),
        .RdAddr(RdAddr), .Imm(Imm), .AluOp(AluOp),
        .AluSrcImm(AluSrcImm), .RegWe(RegWe), .Busy(Busy),
        .Halted(Halted), .Illegal(Illegal), .RetiredCnt(RetiredCnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [20:0] ins(input logic [3:0] op,
        input logic [2:0] rs, input logic [2:0] rt,
        input logic [2:0] rd, input logic [7:0] imm);
        return {op, rs, rt, rd, imm};
    endfunction

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            #1;
        end
    endtask

    // Compare every register-file write against the expected queue
    always @(negedge Clk) begin
        if (RegWe) begin
            if (sbq.size() == 0) begin
                chk("wb_unexp", 1, 0);
            end else begin
                wb_t e;
                e = sbq.pop_front();
                chk("wb_rd", RdAddr, e.rd);
                chk("wb_aluop", AluOp, e.op);
                chk("wb_src", AluSrcImm, e.src);
            end
        end
    end

    task automatic do_branch(input logic [3:0] op, input logic z,
                             input logic [7:0] exp, input string tag);
        mem[8'h00] = ins(4'hA, 0, 0, 0, 8'h10);
        mem[8'h10] = ins(op, 1, 2, 0, 8'h40);
        mem[8'h11] = ins(4'hF, 0, 0, 0, 0);
        mem[8'h40] = ins(4'hF, 0, 0, 0, 0);
        Zero = z;
        Start = 1; tick(1); Start = 0;
        chk({tag, "_a0"}, Addr, 8'h00);
        tick(3);
        chk({tag, "_a10"}, Addr, 8'h10);
        tick(2);
        chk({tag, "_op"}, AluOp, 3'd1);
        tick(1);
        chk({tag, "_tgt"}, Addr, exp);
        tick(3);
        chk({tag, "_halt"}, Halted, 1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = ins(4'hF, 0, 0, 0, 0);
        Rst_n = 0; Start = 0; Zero = 0;
        tick(2);
        chk("rst_addr", Addr, 0);
        chk("rst_we", RegWe, 0);
        chk("rst_aluop", AluOp, 0);
        chk("rst_src", AluSrcImm, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_halt", Halted, 0);
        chk("rst_ill", Illegal, 0);
        chk("rst_cnt", RetiredCnt, 0);
        Rst_n = 1;
        tick(1);

        // ADD r3,r1,r2 then HLT
        mem[0] = ins(4'h1, 1, 2, 3, 0);
        mem[1] = ins(4'hF, 0, 0, 0, 0);
        sbq.push_back('{rd: 3'd3, op: 3'd0, src: 1'b0});
        Start = 1; tick(1); Start = 0;
        chk("add_busy", Busy, 1);
        chk("add_addr", Addr, 0);
        tick(1);
        chk("add_rs", RsAddr, 1);
        chk("add_rt", RtAddr, 2);
        tick(1);
        chk("add_op", AluOp, 0);
        chk("add_we_ex", RegWe, 0);
        tick(1);
        chk("add_we", RegWe, 1);
        chk("add_rd", RdAddr, 3);
        tick(1);
        chk("add_next", Addr, 1);
        tick(3);
        chk("add_halt", Halted, 1);
        chk("add_nbusy", Busy, 0);
        chk("add_cnt", RetiredCnt, 1);

        // LI r1,0x5A from HALT
        mem[0] = ins(4'h7, 0, 0, 1, 8'h5A);
        sbq.push_back('{rd: 3'd1, op: 3'd5, src: 1'b1});
        Start = 1; tick(1); Start = 0;
        chk("li_addr", Addr, 0);
        tick(2);
        chk("li_op", AluOp, 5);
        chk("li_src", AluSrcImm, 1);
        chk("li_imm", Imm, 8'h5A);
        tick(1);
        chk("li_we", RegWe, 1);
        tick(1);
        chk("li_we_off", RegWe, 0);
        chk("li_next", Addr, 1);
        tick(3);
        chk("li_halt", Halted, 1);
        chk("li_cnt", RetiredCnt, 2);

        do_branch(4'h8, 1'b1, 8'h40, "beq_t");
        do_branch(4'h8, 1'b0, 8'h11, "beq_n");
        do_branch(4'h9, 1'b1, 8'h11, "bne_n");
        do_branch(4'h9, 1'b0, 8'h40, "bne_t");
        chk("br_cnt", RetiredCnt, 10);

        // Reset dropped during WB
        mem[0] = ins(4'h1, 1, 2, 3, 0);
        Start = 1; tick(1); Start = 0;
        tick(3);
        Rst_n = 0;
        #1;
        chk("rwb_we", RegWe, 0);
        tick(1);
        chk("rwb_addr", Addr, 0);
        chk("rwb_busy", Busy, 0);
        chk("rwb_cnt", RetiredCnt, 0);
        Rst_n = 1;

        // Start with reset in the same cycle
        Rst_n = 0; Start = 1; tick(1);
        chk("sr_busy", Busy, 0);
        Rst_n = 1; Start = 0; tick(1);
        chk("sr_idle", Busy, 0);

        // Start held while busy is ignored
        sbq.push_back('{rd: 3'd3, op: 3'd0, src: 1'b0});
        Start = 1; tick(4); Start = 0;
        tick(1);
        chk("sb_addr", Addr, 1);
        tick(3);
        chk("sb_halt", Halted, 1);
        chk("sb_cnt", RetiredCnt, 1);

        // PC wrap through NOP at 0xFF
        Rst_n = 0; tick(1); Rst_n = 1;
        mem[0] = ins(4'hA, 0, 0, 0, 8'hFF);
        mem[255] = ins(4'h0, 0, 0, 0, 0);
        Start = 1; tick(1); Start = 0;
        tick(3);
        chk("wr_ff", Addr, 8'hFF);
        tick(3);
        chk("wr_00", Addr, 8'h00);
        chk("wr_cnt", RetiredCnt, 2);

        // Self-branch loop drives the counter into saturation
        Rst_n = 0; tick(1); Rst_n = 1;
        mem[0] = ins(4'h8, 0, 0, 0, 8'h00);
        Zero = 1;
        Start = 1; tick(1); Start = 0;
        force dut.retired_cnt = 16'hFFFD;
        #1;
        release dut.retired_cnt;
        tick(3);
        chk("sat_loop", Addr, 0);
        chk("sat_fffe", RetiredCnt, 16'hFFFE);
        tick(3);
        chk("sat_ffff", RetiredCnt, 16'hFFFF);
        tick(6);
        chk("sat_hold", RetiredCnt, 16'hFFFF);
        chk("sat_busy", Busy, 1);

        // Reserved opcode 0xC
        Rst_n = 0; tick(1); Rst_n = 1;
        mem[0] = ins(4'hC, 0, 0, 0, 0);
        Start = 1; tick(1); Start = 0;
        tick(3);
`ifdef FETCH_SEQ_ILLEGAL_TRAP_EN
        chk("ill_halt", Halted, 1);
        chk("ill_flag", Illegal, 1);
        chk("ill_pc", Addr, 0);
        chk("ill_cnt", RetiredCnt, 0);
        tick(2);
        chk("ill_sticky", Illegal, 1);
        Start = 1; tick(1); Start = 0;
        chk("ill_clr", Illegal, 0);
`else
        chk("ill_busy", Busy, 1);
        chk("ill_flag", Illegal, 0);
        chk("ill_pc", Addr, 1);
        chk("ill_cnt", RetiredCnt, 1);
`endif

        tick(2);
        chk("sb_left", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
